// File: rtl/dest_track_pipe.sv
// Destination-register tracker mirroring EX/MEM/WB: per-operand forwarding selects and load-use stall.
// Optional feature: define LOAD_DEST_EN to track LW destinations and generate load_use_stall.
module dest_track_pipe #(
  parameter int NREGS = 8,
  parameter int DEPTH = 3,
  localparam int REG_W = $clog2(NREGS),
  localparam int SEL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      instr_in,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [REG_W-1:0] src_a,
  input  logic [REG_W-1:0] src_b,
  input  logic             src_a_rd,
  input  logic             src_b_rd,
  output logic [SEL_W-1:0] fwd_sel_a,
  output logic [SEL_W-1:0] fwd_sel_b,
  output logic             load_use_stall,
  output logic [REG_W-1:0] dest_address,
  output logic             valid_bit,
  output logic [SEL_W-1:0] live_count
);

  typedef struct packed {
    logic             valid;
    logic             is_load;
    logic [REG_W-1:0] dest;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  entry_t           dec;
  logic [SEL_W-1:0] live_q;
  logic [SEL_W-1:0] live_d;
  logic             unused_instr_bits;

  assign unused_instr_bits = ^instr_in[2:0];

  // Non-writing or masked instructions decode to an all-zero bubble entry.
  always_comb begin
    dec = '0;
    case (instr_in[15:12])
      4'b0001, 4'b0010: begin
        dec.valid = 1'b1;
        dec.dest  = REG_W'(instr_in[5:3]);
      end
      4'b0000: begin
        dec.valid = 1'b1;
        dec.dest  = REG_W'(instr_in[8:6]);
      end
      4'b0011, 4'b1001, 4'b1010: begin
        dec.valid = 1'b1;
        dec.dest  = REG_W'(instr_in[11:9]);
      end
`ifdef LOAD_DEST_EN
      4'b0100: begin
        dec.valid   = 1'b1;
        dec.is_load = 1'b1;
        dec.dest    = REG_W'(instr_in[11:9]);
      end
`endif
      default: dec = '0;
    endcase
    if (!in_valid) begin
      dec = '0;
    end
  end

  // Flush overrides stall: the pipe still advances, but the issuing slot and old entry 0 die.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      ent_d[k] = ent_q[k];
    end
    if (flush) begin
      ent_d[0] = '0;
      for (int k = 1; k < DEPTH; k++) begin
        ent_d[k] = ent_q[k-1];
        if (k == 1) begin
          ent_d[k].valid = 1'b0;
        end
      end
    end else if (!stall) begin
      ent_d[0] = dec;
      for (int k = 1; k < DEPTH; k++) begin
        ent_d[k] = ent_q[k-1];
      end
    end
    live_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      live_d = live_d + SEL_W'(ent_d[k].valid);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        ent_q[k] <= '0;
      end
      live_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        ent_q[k] <= ent_d[k];
      end
      live_q <= live_d;
    end
  end

  // Scan oldest to youngest so the youngest matching entry overwrites the select.
  always_comb begin
    fwd_sel_a = '0;
    fwd_sel_b = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (ent_q[k].valid && src_a_rd && (ent_q[k].dest == src_a)) begin
        fwd_sel_a = SEL_W'(k + 1);
      end
      if (ent_q[k].valid && src_b_rd && (ent_q[k].dest == src_b)) begin
        fwd_sel_b = SEL_W'(k + 1);
      end
    end
  end

`ifdef LOAD_DEST_EN
  logic match_a0;
  logic match_b0;

  assign match_a0       = src_a_rd && (ent_q[0].dest == src_a);
  assign match_b0       = src_b_rd && (ent_q[0].dest == src_b);
  assign load_use_stall = ent_q[0].valid & ent_q[0].is_load & (match_a0 | match_b0);
`else
  assign load_use_stall = 1'b0;
`endif

  assign dest_address = ent_q[0].dest;
  assign valid_bit    = ent_q[0].valid;
  assign live_count   = live_q;

endmodule

// File: tb/tb_dest_track_pipe.sv
// Scoreboard bench for dest_track_pipe: expected output words queued per driven cycle, popped after the edge.
module tb_dest_track_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr_in;
  logic        in_valid;
  logic        stall;
  logic        flush;
  logic [2:0]  src_a;
  logic [2:0]  src_b;
  logic        src_a_rd;
  logic        src_b_rd;
  logic [1:0]  fwd_sel_a;
  logic [1:0]  fwd_sel_b;
  logic        load_use_stall;
  logic [2:0]  dest_address;
  logic        valid_bit;
  logic [1:0]  live_count;
  logic [10:0] obs;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       name;
    logic [10:0] val;
  } exp_t;

  typedef struct {
    logic [15:0] ins;
    logic        v;
    logic        st;
    logic        fl;
    logic        rst;
    logic [10:0] ex;
  } step_t;

  exp_t sb[$];

  dest_track_pipe dut (
    .clk            (clk),
    .reset          (reset),
    .instr_in       (instr_in),
    .in_valid       (in_valid),
    .stall          (stall),
    .flush          (flush),
    .src_a          (src_a),
    .src_b          (src_b),
    .src_a_rd       (src_a_rd),
    .src_b_rd       (src_b_rd),
    .fwd_sel_a      (fwd_sel_a),
    .fwd_sel_b      (fwd_sel_b),
    .load_use_stall (load_use_stall),
    .dest_address   (dest_address),
    .valid_bit      (valid_bit),
    .live_count     (live_count)
  );

  always #5 clk = ~clk;

  assign obs = {fwd_sel_a, fwd_sel_b, load_use_stall, dest_address, valid_bit, live_count};

  function automatic logic [10:0] mk(int fa, int fb, int lus, int dest, int vb, int live);
    return {2'(fa), 2'(fb), 1'(lus), 3'(dest), 1'(vb), 2'(live)};
  endfunction

  function automatic step_t s(logic [15:0] ins, logic v, logic st, logic fl, logic rst, logic [10:0] ex);
    step_t r;
    r.ins = ins; r.v = v; r.st = st; r.fl = fl; r.rst = rst; r.ex = ex;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input step_t p, input string nm);
    exp_t e;
    reset    = p.rst;
    instr_in = p.ins;
    in_valid = p.v;
    stall    = p.st;
    flush    = p.fl;
    e.name   = nm;
    e.val    = p.ex;
    sb.push_back(e);
  endtask

  task automatic set_src(input logic [2:0] a, input logic ra, input logic [2:0] b, input logic rb);
    src_a = a; src_a_rd = ra; src_b = b; src_b_rd = rb;
  endtask

  task automatic test_reset();
    step_t steps[$];
    exp_t  e;
    set_src(3'd1, 1'b1, 3'd1, 1'b1);
    steps.push_back(s(16'h1B89, 1'b1, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0)));
    steps.push_back(s(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0)));
    steps.push_back(s(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0)));
    foreach (steps[i]) begin
      apply(steps[i], $sformatf("reset[%0d]", i));
      tick();
      e = sb.pop_front();
      n_checks++;
      if (obs !== e.val) begin
        n_errors++;
        $display("FAIL %s: got %b, expected %b", e.name, obs, e.val);
      end
    end
  endtask

  task automatic test_add_fwd();
    step_t steps[$];
    exp_t  e;
    set_src(3'd1, 1'b1, 3'd0, 1'b0);
    steps.push_back(s(16'h1B89, 1'b1, 1'b0, 1'b0, 1'b0, mk(1, 0, 0, 1, 1, 1)));
    steps.push_back(s(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, mk(2, 0, 0, 0, 0, 1)));
    steps.push_back(s(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, mk(3, 0, 0, 0, 0, 1)));
    steps.push_back(s(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0)));
    foreach (steps[i]) begin
      apply(steps[i], $sformatf("add_fwd[%0d]", i));
      tick();
      e = sb.pop_front();
      n_checks++;
      if (obs !== e.val) begin
        n_errors++;
        $display("FAIL %s: got %b, expected %b", e.name, obs, e.val);
      end
    end
  endtask

  task automatic test_youngest();
    step_t steps[$];
    exp_t  e;
    set_src(3'd0, 1'b0, 3'd3, 1'b1);
    steps.push_back(s(16'h00C0, 1'b1, 1'b0, 1'b0, 1'b0, mk(0, 1, 0, 3, 1, 1)));
    steps.push_back(s(16'h2018, 1'b1, 1'b0, 1'b0, 1'b0, mk(0, 1, 0, 3, 1, 2)));
    steps.push_back(s(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 2, 0, 0, 0, 2)));
    steps.push_back(s(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 3, 0, 0, 0, 1)));
    steps.push_back(s(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0)));
    foreach (steps[i]) begin
      apply(steps[i], $sformatf("youngest[%0d]", i));
      tick();
      e = sb.pop_front();
      n_checks++;
      if (obs !== e.val) begin
        n_errors++;
        $display("FAIL %s: got %b, expected %b", e.name, obs, e.val);
      end
    end
  endtask

  task automatic test_load();
    step_t steps[$];
    exp_t  e;
    set_src(3'd5, 1'b1, 3'd0, 1'b0);
`ifdef LOAD_DEST_EN
    steps.push_back(s(16'h4B89, 1'b1, 1'b0, 1'b0, 1'b0, mk(1, 0, 1, 5, 1, 1)));
    steps.push_back(s(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, mk(2, 0, 0, 0, 0, 1)));
    steps.push_back(s(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, mk(3, 0, 0, 0, 0, 1)));
`else
    steps.push_back(s(16'h4B89, 1'b1, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0)));
    steps.push_back(s(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0)));
    steps.push_back(s(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0)));
`endif
    steps.push_back(s(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0)));
    foreach (steps[i]) begin
      apply(steps[i], $sformatf("load[%0d]", i));
      tick();
      e = sb.pop_front();
      n_checks++;
      if (obs !== e.val) begin
        n_errors++;
        $display("FAIL %s: got %b, expected %b", e.name, obs, e.val);
      end
    end
  endtask

  task automatic test_stall();
    step_t steps[$];
    exp_t  e;
    set_src(3'd5, 1'b1, 3'd5, 1'b1);
    steps.push_back(s(16'h9A00, 1'b1, 1'b0, 1'b0, 1'b0, mk(1, 1, 0, 5, 1, 1)));
    steps.push_back(s(16'h1B89, 1'b1, 1'b1, 1'b0, 1'b0, mk(1, 1, 0, 5, 1, 1)));
    steps.push_back(s(16'h1B89, 1'b1, 1'b1, 1'b0, 1'b0, mk(1, 1, 0, 5, 1, 1)));
    steps.push_back(s(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, mk(2, 2, 0, 0, 0, 1)));
    steps.push_back(s(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, mk(3, 3, 0, 0, 0, 1)));
    steps.push_back(s(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0)));
    foreach (steps[i]) begin
      apply(steps[i], $sformatf("stall[%0d]", i));
      tick();
      e = sb.pop_front();
      n_checks++;
      if (obs !== e.val) begin
        n_errors++;
        $display("FAIL %s: got %b, expected %b", e.name, obs, e.val);
      end
    end
  endtask

  task automatic test_flush();
    step_t steps[$];
    exp_t  e;
    // Flush with stall: the ADD in entry 0 is killed and the issuing ADI never lands.
    set_src(3'd1, 1'b1, 3'd3, 1'b1);
    steps.push_back(s(16'h1B89, 1'b1, 1'b0, 1'b0, 1'b0, mk(1, 0, 0, 1, 1, 1)));
    steps.push_back(s(16'h00C0, 1'b1, 1'b1, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0)));
    steps.push_back(s(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0)));
    steps.push_back(s(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0)));
    foreach (steps[i]) begin
      apply(steps[i], $sformatf("flush_stall[%0d]", i));
      tick();
      e = sb.pop_front();
      n_checks++;
      if (obs !== e.val) begin
        n_errors++;
        $display("FAIL %s: got %b, expected %b", e.name, obs, e.val);
      end
    end
    // Killed younger R1 writer must not shadow the older live R1 writer.
    steps.delete();
    set_src(3'd1, 1'b1, 3'd0, 1'b0);
    steps.push_back(s(16'h1B89, 1'b1, 1'b0, 1'b0, 1'b0, mk(1, 0, 0, 1, 1, 1)));
    steps.push_back(s(16'h1B89, 1'b1, 1'b0, 1'b0, 1'b0, mk(1, 0, 0, 1, 1, 2)));
    steps.push_back(s(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, mk(3, 0, 0, 0, 0, 1)));
    steps.push_back(s(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0)));
    foreach (steps[i]) begin
      apply(steps[i], $sformatf("flush_shadow[%0d]", i));
      tick();
      e = sb.pop_front();
      n_checks++;
      if (obs !== e.val) begin
        n_errors++;
        $display("FAIL %s: got %b, expected %b", e.name, obs, e.val);
      end
    end
  endtask

  task automatic test_misc();
    step_t steps[$];
    exp_t  e;
    set_src(3'd5, 1'b1, 3'd5, 1'b1);
    steps.push_back(s(16'h8A00, 1'b1, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0)));
    steps.push_back(s(16'h1B89, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0)));
    foreach (steps[i]) begin
      apply(steps[i], $sformatf("unsupported[%0d]", i));
      tick();
      e = sb.pop_front();
      n_checks++;
      if (obs !== e.val) begin
        n_errors++;
        $display("FAIL %s: got %b, expected %b", e.name, obs, e.val);
      end
    end
    // Matching address but read enables low, then raise src_a_rd combinationally.
    steps.delete();
    set_src(3'd1, 1'b0, 3'd1, 1'b0);
    steps.push_back(s(16'h1B89, 1'b1, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 1, 1, 1)));
    foreach (steps[i]) begin
      apply(steps[i], $sformatf("rd_off[%0d]", i));
      tick();
      e = sb.pop_front();
      n_checks++;
      if (obs !== e.val) begin
        n_errors++;
        $display("FAIL %s: got %b, expected %b", e.name, obs, e.val);
      end
    end
    instr_in = 16'h0000;
    in_valid = 1'b0;
    src_a_rd = 1'b1;
    sb.push_back('{"rd_on", mk(1, 0, 0, 1, 1, 1)});
    #1;
    e = sb.pop_front();
    n_checks++;
    if (obs !== e.val) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b", e.name, obs, e.val);
    end
    steps.delete();
    steps.push_back(s(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, mk(2, 0, 0, 0, 0, 1)));
    steps.push_back(s(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, mk(3, 0, 0, 0, 0, 1)));
    steps.push_back(s(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0)));
    foreach (steps[i]) begin
      apply(steps[i], $sformatf("rd_drain[%0d]", i));
      tick();
      e = sb.pop_front();
      n_checks++;
      if (obs !== e.val) begin
        n_errors++;
        $display("FAIL %s: got %b, expected %b", e.name, obs, e.val);
      end
    end
  endtask

  task automatic test_reset_mid();
    step_t steps[$];
    exp_t  e;
    set_src(3'd5, 1'b1, 3'd1, 1'b1);
    steps.push_back(s(16'h9A00, 1'b1, 1'b0, 1'b0, 1'b0, mk(1, 0, 0, 5, 1, 1)));
    steps.push_back(s(16'h1B89, 1'b1, 1'b0, 1'b0, 1'b0, mk(2, 1, 0, 1, 1, 2)));
    steps.push_back(s(16'h2018, 1'b1, 1'b0, 1'b0, 1'b0, mk(3, 2, 0, 3, 1, 3)));
    steps.push_back(s(16'h1B89, 1'b1, 1'b1, 1'b1, 1'b1, mk(0, 0, 0, 0, 0, 0)));
    steps.push_back(s(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0)));
    foreach (steps[i]) begin
      apply(steps[i], $sformatf("reset_mid[%0d]", i));
      tick();
      e = sb.pop_front();
      n_checks++;
      if (obs !== e.val) begin
        n_errors++;
        $display("FAIL %s: got %b, expected %b", e.name, obs, e.val);
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    instr_in = 16'h0000;
    in_valid = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    set_src(3'd0, 1'b0, 3'd0, 1'b0);
    test_reset();
    test_add_fwd();
    test_youngest();
    test_load();
    test_stall();
    test_flush();
    test_misc();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
